// File: rtl/sort_job_scheduler.sv
// rtl/sort_job_scheduler.sv - round-robin scheduler sharing one sort engine among several requesters
module sort_job_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int DW       = 4,
  parameter int NUM_ELEM = 4,
  parameter int TIMEOUT  = 255,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*NUM_ELEM*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_ELEM*DW-1:0]       eng_data,
  output logic                         eng_start,
  input  logic                         eng_dout_valid,
  input  logic [DW-1:0]                eng_dout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic [NUM_ELEM*DW-1:0]       rsp_data,
  output logic                         rsp_timeout,
  output logic                         busy
);

  localparam int VW  = NUM_ELEM * DW;
  localparam int BCW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_COLLECT,
    S_RESP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] beat_cnt;
  logic [TW-1:0]  timer;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           last_beat;
  logic           final_write;
  logic           timer_expired;

  assign last_beat     = (beat_cnt == BCW'(NUM_ELEM - 1));
  assign final_write   = eng_dout_valid && last_beat;
  assign timer_expired = (timer == TW'(TIMEOUT - 1));

  // Round-robin search from rr_ptr; scanning offsets high-to-low lets the lowest offset win
  always_comb begin
    int cand;
    logic [IDW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand     = (int'(rr_ptr) + i) % NUM_REQ;
      cand_idx = cand[IDW-1:0];
      if (req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // One-hot acceptance, only offered while idle
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:    if (grant_found) state_nxt = S_START;
      S_START: begin
        eng_start = 1'b1;
        state_nxt = S_COLLECT;
      end
      S_COLLECT: if (final_write || timer_expired) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Job capture, beat collection, watchdog and round-robin pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      timer       <= '0;
      eng_data    <= '0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            eng_data    <= req_data[grant_idx*VW +: VW];
            rsp_id      <= grant_idx;
            rsp_data    <= '0;
            beat_cnt    <= '0;
            rsp_timeout <= 1'b0;
          end
        end
        S_START: timer <= '0;
        S_COLLECT: begin
          if (eng_dout_valid) begin
            rsp_data[beat_cnt*DW +: DW] <= eng_dout;
            beat_cnt                    <= beat_cnt + 1'b1;
          end
          // A final beat landing on the expiry cycle completes the job normally
          if (!final_write) begin
            if (timer_expired) rsp_timeout <= 1'b1;
            else               timer       <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
